// File: rtl/ssp_pkg.sv
// Shared definitions for the SSP link blocks.
package ssp_pkg;

    // Frame width carried on the SSP link.
    localparam int SSP_DATA_W = 8;

    // Receive deserialiser states, shared with future SSP master/slave blocks.
    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } ssp_rx_state_t;

endpackage : ssp_pkg

// File: rtl/ssp_rx_fifo.sv
// First-word-fall-through receive FIFO with overrun flag.
// A push into a full FIFO is dropped unless a pop frees a slot in the same cycle.
module ssp_rx_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              full,
    output logic              overrun
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic [CNT_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if a pop frees a slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head byte falls through; forced to zero while empty so the output is defined after reset.
    assign rdata   = empty ? '0 : mem[rptr];

    // Storage write port.
    // NOTE: the storage array has no reset; it is never read while empty, so clearing it buys nothing.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // Pointers, occupancy count and the registered overrun pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
            overrun <= push && !do_push;
        end
    end

endmodule : ssp_rx_fifo

// File: rtl/ssp_rx.sv
// SSP serial receiver: synchronises the far-end clock, frame sync and data,
// deserialises MSB-first frames and buffers completed bytes in a small FIFO.
module ssp_rx
    import ssp_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = SSP_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sspclkin,
    input  logic              sspfssin,
    input  logic              ssprxd,
    input  logic              do_read,
    output logic [DATA_W-1:0] rx_d,
    output logic              rx_empty,
    output logic              rx_full,
    output logic              rx_overrun
);
    localparam int                BCNT_W    = $clog2(DATA_W);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(DATA_W - 1);

    // Synchroniser chains: bit 0 is the first stage, bit 1 the usable output.
    logic [1:0]        clk_sync;
    logic [1:0]        fss_sync;
    logic [1:0]        rxd_sync;
    logic              clk_prev;
    logic              fe;
    logic              fss;
    logic              rxd;
    ssp_rx_state_t     state;
    logic [BCNT_W-1:0] bcnt;
    logic [DATA_W-1:0] sr;
    logic [DATA_W-1:0] next_byte;
    logic              push;

    // Two-flop synchronisers plus a delayed copy of the synchronised serial clock.
    // NOTE: non-blocking assignments let each stage capture the previous stage's old value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync <= '0;
            fss_sync <= '0;
            rxd_sync <= '0;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], sspclkin};
            fss_sync <= {fss_sync[0], sspfssin};
            rxd_sync <= {rxd_sync[0], ssprxd};
            clk_prev <= clk_sync[1];
        end
    end

    // Falling edge of the serial clock is the sample strobe for fss and data.
    assign fe        = clk_prev && !clk_sync[1];
    assign fss       = fss_sync[1];
    assign rxd       = rxd_sync[1];
    assign next_byte = {sr[DATA_W-2:0], rxd};
    // The byte is handed to the FIFO on the same edge the last bit is sampled.
    assign push      = fe && (state == RX_SHIFT) && (bcnt == BCNT_LAST);

    // Frame FSM with bit counter and shift register; fss mid-frame restarts the frame.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= RX_IDLE;
            bcnt  <= '0;
            sr    <= '0;
        end else if (fe) begin
            case (state)
                RX_IDLE: begin
                    if (fss) begin
                        state <= RX_SHIFT;
                        bcnt  <= '0;
                    end
                end
                RX_SHIFT: begin
                    if (bcnt == BCNT_LAST) begin
                        sr   <= next_byte;
                        bcnt <= '0;
                        if (!fss) begin
                            state <= RX_IDLE;
                        end
                    end else if (fss) begin
                        sr   <= '0;
                        bcnt <= '0;
                    end else begin
                        sr   <= next_byte;
                        bcnt <= bcnt + 1'b1;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    ssp_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push    (push),
        .pop     (do_read),
        .wdata   (next_byte),
        .rdata   (rx_d),
        .empty   (rx_empty),
        .full    (rx_full),
        .overrun (rx_overrun)
    );

endmodule : ssp_rx

// File: tb/tb_ssp_rx.sv
// Self-checking bench for ssp_rx: directed tables, hand-timed corner cases
// and randomized frames checked against a queue-based model.
module tb_ssp_rx;

    localparam int DEPTH = 4;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       sspclkin = 1'b0;
    logic       sspfssin = 1'b0;
    logic       ssprxd = 1'b0;
    logic       do_read = 1'b0;
    logic [7:0] rx_d;
    logic       rx_empty;
    logic       rx_full;
    logic       rx_overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int ovr_cnt = 0;

    typedef struct {
        logic       is_pop;
        logic [7:0] data;
        logic [7:0] exp_d;
        logic       exp_empty;
        logic       exp_full;
        int         exp_ovr;
    } vec_t;

    vec_t       vecs [12];
    logic [7:0] model_q [$];
    int         exp_ovr;
    int         ovr_base;

    ssp_rx #(
        .DEPTH  (DEPTH),
        .DATA_W (8)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .sspclkin   (sspclkin),
        .sspfssin   (sspfssin),
        .ssprxd     (ssprxd),
        .do_read    (do_read),
        .rx_d       (rx_d),
        .rx_empty   (rx_empty),
        .rx_full    (rx_full),
        .rx_overrun (rx_overrun)
    );

    always #10 clk_i = ~clk_i;

    // Count cycles with the overrun flag high, sampled away from the active edge.
    always @(negedge clk_i) begin
        if (rx_overrun === 1'b1) ovr_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One serial period: data/fss change with the rising edge, sampled at the falling edge.
    task automatic tx_bit(input logic f, input logic d);
        sspclkin = 1'b1;
        sspfssin = f;
        ssprxd   = d;
        #40;
        sspclkin = 1'b0;
        #40;
    endtask

    task automatic tx_fss();
        tx_bit(1'b1, 1'b0);
    endtask

    // Send a byte MSB first; returns at the LSB falling edge.
    task automatic tx_frame_hold(input logic [7:0] b, input logic fss_lsb);
        for (int i = 7; i >= 1; i--) tx_bit(1'b0, b[i]);
        sspclkin = 1'b1;
        sspfssin = fss_lsb;
        ssprxd   = b[0];
        #40;
        sspclkin = 1'b0;
    endtask

    task automatic tx_frame(input logic [7:0] b, input logic fss_lsb);
        tx_frame_hold(b, fss_lsb);
        #40;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk_i);
    endtask

    task automatic pop();
        @(negedge clk_i);
        do_read = 1'b1;
        @(negedge clk_i);
        do_read = 1'b0;
    endtask

    // Pop with a check of the byte at the head first.
    task automatic pop_expect(input string name, input logic [7:0] exp);
        check({name, "_empty"}, {31'd0, rx_empty}, 32'd0);
        check({name, "_data"}, {24'd0, rx_d}, {24'd0, exp});
        pop();
    endtask

    initial begin
        // Directed table: fill past full, drain, pop while empty, refill.
        vecs[0]  = '{1'b0, 8'h01, 8'h01, 1'b0, 1'b0, 0};
        vecs[1]  = '{1'b0, 8'h02, 8'h01, 1'b0, 1'b0, 0};
        vecs[2]  = '{1'b0, 8'h03, 8'h01, 1'b0, 1'b0, 0};
        vecs[3]  = '{1'b0, 8'h04, 8'h01, 1'b0, 1'b1, 0};
        vecs[4]  = '{1'b0, 8'h05, 8'h01, 1'b0, 1'b1, 1};
        vecs[5]  = '{1'b1, 8'h00, 8'h02, 1'b0, 1'b0, 1};
        vecs[6]  = '{1'b1, 8'h00, 8'h03, 1'b0, 1'b0, 1};
        vecs[7]  = '{1'b1, 8'h00, 8'h04, 1'b0, 1'b0, 1};
        vecs[8]  = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1};
        vecs[9]  = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1};
        vecs[10] = '{1'b0, 8'hC3, 8'hC3, 1'b0, 1'b0, 1};
        vecs[11] = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1};

        // Reset values while reset is held.
        #25;
        check("rst_rx_d", {24'd0, rx_d}, 32'd0);
        check("rst_empty", {31'd0, rx_empty}, 32'd1);
        check("rst_full", {31'd0, rx_full}, 32'd0);
        check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // Single frame 0x55: rx_empty falls at the third clk edge after the LSB falling edge.
        tx_fss();
        tx_frame_hold(8'h55, 1'b0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        check("lat_edge1_empty", {31'd0, rx_empty}, 32'd1);
        @(posedge clk_i);
        #1;
        check("lat_edge2_empty", {31'd0, rx_empty}, 32'd0);
        check("lat_edge2_data", {24'd0, rx_d}, 32'h55);
        settle();
        pop();
        check("single_pop_empty", {31'd0, rx_empty}, 32'd1);

        // Back-to-back frames with fss during the previous LSB period.
        tx_fss();
        tx_frame(8'hA5, 1'b1);
        tx_frame(8'h3C, 1'b1);
        tx_frame(8'hFF, 1'b0);
        settle();
        check("b2b_full", {31'd0, rx_full}, 32'd0);
        pop_expect("b2b_0", 8'hA5);
        pop_expect("b2b_1", 8'h3C);
        pop_expect("b2b_2", 8'hFF);
        check("b2b_drained", {31'd0, rx_empty}, 32'd1);

        // Table: overrun, drain, ignored pop while empty.
        ovr_base = ovr_cnt;
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].is_pop) begin
                pop();
            end else begin
                tx_fss();
                tx_frame(vecs[i].data, 1'b0);
                settle();
            end
            check($sformatf("vec%0d_empty", i), {31'd0, rx_empty}, {31'd0, vecs[i].exp_empty});
            check($sformatf("vec%0d_full", i), {31'd0, rx_full}, {31'd0, vecs[i].exp_full});
            check($sformatf("vec%0d_ovr", i), ovr_cnt - ovr_base, vecs[i].exp_ovr);
            if (!vecs[i].exp_empty)
                check($sformatf("vec%0d_data", i), {24'd0, rx_d}, {24'd0, vecs[i].exp_d});
        end

        // Resync: fss after 3 bits of 0xF0, then a full 0x81.
        tx_fss();
        tx_bit(1'b0, 1'b1);
        tx_bit(1'b0, 1'b1);
        tx_bit(1'b0, 1'b1);
        tx_fss();
        tx_frame(8'h81, 1'b0);
        settle();
        pop_expect("resync", 8'h81);
        check("resync_one_byte", {31'd0, rx_empty}, 32'd1);

        // Full FIFO plus a pop on the push edge of 0x77.
        for (int i = 0; i < 4; i++) begin
            tx_fss();
            tx_frame(8'h10 + 8'(i), 1'b0);
        end
        settle();
        check("fullpop_full_before", {31'd0, rx_full}, 32'd1);
        ovr_base = ovr_cnt;
        tx_fss();
        tx_frame_hold(8'h77, 1'b0);
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        do_read = 1'b1;
        @(negedge clk_i);
        do_read = 1'b0;
        settle();
        check("fullpop_no_ovr", ovr_cnt - ovr_base, 32'd0);
        check("fullpop_full_after", {31'd0, rx_full}, 32'd1);
        pop_expect("fullpop_0", 8'h11);
        pop_expect("fullpop_1", 8'h12);
        pop_expect("fullpop_2", 8'h13);
        pop_expect("fullpop_3", 8'h77);
        check("fullpop_drained", {31'd0, rx_empty}, 32'd1);

        // Reset mid-frame with a byte already buffered.
        tx_fss();
        tx_frame(8'h42, 1'b0);
        tx_fss();
        tx_bit(1'b0, 1'b1);
        tx_bit(1'b0, 1'b0);
        tx_bit(1'b0, 1'b1);
        tx_bit(1'b0, 1'b1);
        rst_ni = 1'b0;
        #5;
        check("midrst_rx_d", {24'd0, rx_d}, 32'd0);
        check("midrst_empty", {31'd0, rx_empty}, 32'd1);
        check("midrst_full", {31'd0, rx_full}, 32'd0);
        check("midrst_overrun", {31'd0, rx_overrun}, 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        tx_fss();
        tx_frame(8'h99, 1'b0);
        settle();
        pop_expect("midrst_after", 8'h99);
        check("midrst_one_byte", {31'd0, rx_empty}, 32'd1);

        // Randomized frames, optional aborted partials and random reads against a queue model.
        ovr_base = ovr_cnt;
        exp_ovr  = 0;
        model_q.delete();
        for (int f = 0; f < 24; f++) begin
            logic [7:0] b;
            int         nrd;
            b = 8'($urandom);
            tx_fss();
            if ($urandom_range(0, 3) == 0) begin
                int k;
                k = $urandom_range(0, 6);
                for (int i = 0; i < k; i++) tx_bit(1'b0, 1'($urandom_range(0, 1)));
                tx_fss();
            end
            tx_frame(b, 1'b0);
            settle();
            if (model_q.size() < DEPTH) model_q.push_back(b);
            else exp_ovr++;
            check($sformatf("rnd%0d_ovr", f), ovr_cnt - ovr_base, exp_ovr);
            check($sformatf("rnd%0d_full", f), {31'd0, rx_full}, {31'd0, model_q.size() == DEPTH});
            nrd = $urandom_range(0, 3);
            for (int r = 0; r < nrd; r++) begin
                check($sformatf("rnd%0d_empty", f), {31'd0, rx_empty}, {31'd0, model_q.size() == 0});
                if (model_q.size() > 0) begin
                    check($sformatf("rnd%0d_data", f), {24'd0, rx_d}, {24'd0, model_q[0]});
                    void'(model_q.pop_front());
                end
                pop();
            end
        end
        while (model_q.size() > 0) begin
            pop_expect("rnd_drain", model_q[0]);
            void'(model_q.pop_front());
        end
        check("rnd_drained", {31'd0, rx_empty}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_ssp_rx
